// File: rtl/clint_timer.sv
// ============================================================================
// Module      : clint_timer
// Description : Memory-mapped machine timer (mtime/mtimecmp) and software
//               interrupt (msip) source feeding the core's interrupt inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clint_timer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0200_0000,
    parameter int                    PRESCALE   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  irq_timer_o,
    output logic                  irq_software_o
);

    // Word offsets (byte offset >> 2) within the block.
    localparam logic [13:0] c_word_msip     = 14'h0000;
    localparam logic [13:0] c_word_cmp_lo   = 14'h1000;
    localparam logic [13:0] c_word_cmp_hi   = 14'h1001;
    localparam logic [13:0] c_word_mtime_lo = 14'h2FFE;
    localparam logic [13:0] c_word_mtime_hi = 14'h2FFF;

    logic        w_sel;
    logic        w_wr;
    logic        w_rd;
    logic [13:0] w_word;
    logic [31:0] w_wdata;
    logic        w_wr_msip;
    logic        w_wr_cmp_lo;
    logic        w_wr_cmp_hi;
    logic        w_wr_mtime_lo;
    logic        w_wr_mtime_hi;
    logic        w_tick;
    logic        w_unused_addr;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic        r_irq_timer;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_sel   = ce_i && (addr_i[ADDR_WIDTH-1:16] == BASE_ADDR[ADDR_WIDTH-1:16]);
    assign w_wr    = w_sel && we_i;
    assign w_rd    = w_sel && !we_i;
    assign w_word  = addr_i[15:2];
    assign w_wdata = wdata_i[31:0];

    // Byte lane bits carry no meaning: only full-word accesses exist.
    assign w_unused_addr = ^addr_i[1:0];

    assign w_wr_msip     = w_wr && (w_word == c_word_msip);
    assign w_wr_cmp_lo   = w_wr && (w_word == c_word_cmp_lo);
    assign w_wr_cmp_hi   = w_wr && (w_word == c_word_cmp_hi);
    assign w_wr_mtime_lo = w_wr && (w_word == c_word_mtime_lo);
    assign w_wr_mtime_hi = w_wr && (w_word == c_word_mtime_hi);

    generate
        if (PRESCALE <= 1) begin : g_prescale_bypass
            assign w_tick = 1'b1;
        end else begin : g_prescale_cnt
            localparam int                  c_pcnt_w   = $clog2(PRESCALE);
            localparam logic [c_pcnt_w-1:0] c_pcnt_max = c_pcnt_w'(PRESCALE - 1);

            logic [c_pcnt_w-1:0] r_pcnt;

            // Free-running; bus traffic never disturbs the tick phase.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_pcnt <= '0;
                end else if (r_pcnt == c_pcnt_max) begin
                    r_pcnt <= '0;
                end else begin
                    r_pcnt <= r_pcnt + c_pcnt_w'(1);
                end
            end

            assign w_tick = (r_pcnt == c_pcnt_max);
        end
    endgenerate

    // A write to either half freezes the whole counter for that cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mtime <= '0;
        end else if (w_wr_mtime_lo || w_wr_mtime_hi) begin
            if (w_wr_mtime_lo) begin
                r_mtime[31:0] <= w_wdata;
            end
            if (w_wr_mtime_hi) begin
                r_mtime[63:32] <= w_wdata;
            end
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mtimecmp <= '1;
        end else begin
            if (w_wr_cmp_lo) begin
                r_mtimecmp[31:0] <= w_wdata;
            end
            if (w_wr_cmp_hi) begin
                r_mtimecmp[63:32] <= w_wdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_msip      <= 1'b0;
            r_irq_timer <= 1'b0;
        end else begin
            if (w_wr_msip) begin
                r_msip <= w_wdata[0];
            end
            r_irq_timer <= (r_mtime >= r_mtimecmp);
        end
    end

    // Zero when unselected so the result can be OR-ed with RAM read data.
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_word)
                c_word_msip:     w_rdata = {{(DATA_WIDTH-1){1'b0}}, r_msip};
                c_word_cmp_lo:   w_rdata = r_mtimecmp[31:0];
                c_word_cmp_hi:   w_rdata = r_mtimecmp[63:32];
                c_word_mtime_lo: w_rdata = r_mtime[31:0];
                c_word_mtime_hi: w_rdata = r_mtime[63:32];
                default:         w_rdata = '0;
            endcase
        end
    end

    assign rdata_o        = w_rdata;
    assign irq_timer_o    = r_irq_timer;
    assign irq_software_o = r_msip;

endmodule

`default_nettype wire

// File: tb/tb_clint_timer.sv
// ============================================================================
// Module      : tb_clint_timer
// Description : Directed self-checking bench for clint_timer (PRESCALE 1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clint_timer;

    localparam logic [31:0] c_msip     = 32'h0200_0000;
    localparam logic [31:0] c_cmp_lo   = 32'h0200_4000;
    localparam logic [31:0] c_cmp_hi   = 32'h0200_4004;
    localparam logic [31:0] c_mtime_lo = 32'h0200_BFF8;
    localparam logic [31:0] c_mtime_hi = 32'h0200_BFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic        ce1;
    logic        ce4;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd1;
    logic [31:0] rd4;
    logic        irq_t1;
    logic        irq_s1;
    logic        irq_t4;
    logic        irq_s4;

    int n_checks = 0;
    int n_errors = 0;
    int pc;

    always #5 clk = ~clk;

    // Rising edges since reset release; gives the PRESCALE=4 phase.
    always @(posedge clk) begin
        if (!rst_n) pc <= 0;
        else        pc <= pc + 1;
    end

    clint_timer #(.PRESCALE(1)) u_dut1 (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .ce_i           (ce1),
        .we_i           (we),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .rdata_o        (rd1),
        .irq_timer_o    (irq_t1),
        .irq_software_o (irq_s1)
    );

    clint_timer #(.PRESCALE(4)) u_dut4 (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .ce_i           (ce4),
        .we_i           (we),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .rdata_o        (rd4),
        .irq_timer_o    (irq_t4),
        .irq_software_o (irq_s4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input bit d4, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        if (d4) ce4 = 1'b1;
        else    ce1 = 1'b1;
        @(posedge clk);
        #1;
        ce1 = 1'b0;
        ce4 = 1'b0;
        we  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input bit d4, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] q;
        @(negedge clk);
        addr = a;
        we   = 1'b0;
        if (d4) ce4 = 1'b1;
        else    ce1 = 1'b1;
        #1;
        q   = d4 ? rd4 : rd1;
        ce1 = 1'b0;
        ce4 = 1'b0;
        check_eq(tag, q, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ce1   = 1'b0;
        ce4   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        rd_chk("rst_mtime_lo", 1'b0, c_mtime_lo, 32'h0);
        check_eq("rst_irq_t1", {31'b0, irq_t1}, 32'h0);
        check_eq("rst_irq_s1", {31'b0, irq_s1}, 32'h0);
        check_eq("rst_irq_t4", {31'b0, irq_t4}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("mtime_run1", 1'b0, c_mtime_lo, 32'd1);
        rd_chk("mtime_run2", 1'b0, c_mtime_lo, 32'd2);
        rd_chk("rst_cmp_lo", 1'b0, c_cmp_lo, 32'hFFFF_FFFF);
        rd_chk("rst_cmp_hi", 1'b0, c_cmp_hi, 32'hFFFF_FFFF);
        rd_chk("outside_base", 1'b0, 32'h0300_4000, 32'h0);
        @(negedge clk);
        #1;
        check_eq("ce_low_rdata", rd1, 32'h0);
        check_eq("idle_irq_t1", {31'b0, irq_t1}, 32'h0);
        check_eq("idle_irq_s1", {31'b0, irq_s1}, 32'h0);

        // Timer interrupt, PRESCALE=1
        bus_wr(1'b0, c_mtime_hi, 32'h0);
        bus_wr(1'b0, c_mtime_lo, 32'h0);
        bus_wr(1'b0, c_cmp_hi, 32'h0);
        bus_wr(1'b0, c_cmp_lo, 32'd20);
        repeat (18) @(negedge clk);
        rd_chk("mtime_at_20", 1'b0, c_mtime_lo, 32'd20);
        check_eq("irq_before_rise", {31'b0, irq_t1}, 32'h0);
        @(negedge clk);
        #1;
        check_eq("irq_rise", {31'b0, irq_t1}, 32'h1);
        bus_wr(1'b0, c_cmp_lo, 32'd1000);
        @(negedge clk);
        #1;
        check_eq("irq_hold_after_wr", {31'b0, irq_t1}, 32'h1);
        @(negedge clk);
        #1;
        check_eq("irq_fall", {31'b0, irq_t1}, 32'h0);
        rd_chk("cmp_lo_readback", 1'b0, c_cmp_lo, 32'd1000);
        rd_chk("addr_lsb_ignored", 1'b0, c_cmp_lo | 32'h3, 32'd1000);

        // Carry and full wrap
        bus_wr(1'b0, c_mtime_lo, 32'hFFFF_FFFE);
        bus_wr(1'b0, c_mtime_hi, 32'hFFFF_FFFF);
        rd_chk("wrap_lo_pre", 1'b0, c_mtime_lo, 32'hFFFF_FFFE);
        rd_chk("wrap_hi_pre", 1'b0, c_mtime_hi, 32'hFFFF_FFFF);
        rd_chk("wrap_lo_post", 1'b0, c_mtime_lo, 32'h0);
        rd_chk("wrap_hi_post", 1'b0, c_mtime_hi, 32'h0);
        bus_wr(1'b0, c_mtime_lo, 32'hFFFF_FFFF);
        bus_wr(1'b0, c_mtime_hi, 32'd5);
        rd_chk("carry_hi_pre", 1'b0, c_mtime_hi, 32'd5);
        rd_chk("carry_hi_post", 1'b0, c_mtime_hi, 32'd6);
        rd_chk("carry_lo_post", 1'b0, c_mtime_lo, 32'd1);

        // Write on a tick cycle wins over the increment
        bus_wr(1'b0, c_mtime_lo, 32'h100);
        rd_chk("collide_lo", 1'b0, c_mtime_lo, 32'h100);
        rd_chk("collide_hi", 1'b0, c_mtime_hi, 32'd6);

        // Software interrupt
        bus_wr(1'b0, c_msip, 32'hFFFF_FFFF);
        rd_chk("msip_read", 1'b0, c_msip, 32'h1);
        check_eq("msip_irq_on", {31'b0, irq_s1}, 32'h1);
        bus_wr(1'b0, c_msip | 32'h10, 32'h0);
        rd_chk("msip_unmapped_wr", 1'b0, c_msip, 32'h1);
        rd_chk("unmapped_read", 1'b0, c_msip | 32'h10, 32'h0);
        check_eq("msip_irq_still", {31'b0, irq_s1}, 32'h1);
        bus_wr(1'b0, c_msip, 32'h0);
        @(negedge clk);
        #1;
        check_eq("msip_irq_off", {31'b0, irq_s1}, 32'h0);
        rd_chk("msip_read_off", 1'b0, c_msip, 32'h0);

        // PRESCALE=4: write lands at phase 1; next tick still at phase 3->0
        do @(negedge clk); while (pc % 4 != 0);
        bus_wr(1'b1, c_mtime_lo, 32'h50);
        rd_chk("psc_hold1", 1'b1, c_mtime_lo, 32'h50);
        rd_chk("psc_hold2", 1'b1, c_mtime_lo, 32'h50);
        rd_chk("psc_tick1", 1'b1, c_mtime_lo, 32'h51);
        rd_chk("psc_hold3", 1'b1, c_mtime_lo, 32'h51);
        rd_chk("psc_hold4", 1'b1, c_mtime_lo, 32'h51);
        rd_chk("psc_hold5", 1'b1, c_mtime_lo, 32'h51);
        rd_chk("psc_tick2", 1'b1, c_mtime_lo, 32'h52);
        check_eq("psc_irq_t4", {31'b0, irq_t4}, 32'h0);
        check_eq("psc_irq_s4", {31'b0, irq_s4}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clint_timer.md
# clint_timer

Memory-mapped machine timer and software-interrupt source that sits directly upstream of the core's interrupt inputs. It decodes accesses from the core's data-memory port (ce/we/addr/wdata/rdata) and drives `irq_timer_i` and `irq_software_i` of the core. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a 1-bit `msip`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, bus address width
- `DATA_WIDTH`, 32, bus data width; fixed at 32
- `BASE_ADDR`, 32'h0200_0000, block base address; upper 16 bits are decoded
- `PRESCALE`, 1, number of `clk_i` cycles per `mtime` increment; must be ≥1

Ports:
- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `ce_i`  in  1  bus access strobe from the core's data port
- `we_i`  in  1  1 = write, 0 = read; qualified by `ce_i`
- `addr_i`  in  ADDR_WIDTH  byte address
- `wdata_i`  in  DATA_WIDTH  write data (full word)
- `rdata_o`  out  DATA_WIDTH  read data, combinational
- `irq_timer_o`  out  1  to core `irq_timer_i`
- `irq_software_o`  out  1  to core `irq_software_i`

## Operation
- Select: `sel = ce_i && addr_i[31:16] == BASE_ADDR[31:16]`. `addr_i[1:0]` is ignored. Only word accesses exist; there are no byte enables.
- Register map, using offset `addr_i[15:0]`:
  - 0x0000: MSIP. Bit 0 is R/W; bits 31:1 read as 0.
  - 0x4000: MTIMECMP_LO
  - 0x4004: MTIMECMP_HI
  - 0xBFF8: MTIME_LO
  - 0xBFFC: MTIME_HI
  - Any other offset reads 0 and writes are ignored.
- Reads: `rdata_o` = the selected register's current value when `sel && !we_i`; otherwise `rdata_o` = 0, so it can be OR-muxed with RAM data.
- Writes: take effect at the rising edge when `sel && we_i`. Only the addressed half is written; the other half holds.
- Prescaler:
  - Counter `pcnt` runs 0..PRESCALE-1. `tick` = (`pcnt` == PRESCALE-1), after which `pcnt` wraps to 0.
  - With PRESCALE=1, `tick` = 1 every cycle.
  - `pcnt` is never affected by bus writes.
- mtime:
  - On `tick`, mtime ← mtime + 1 as a full 64-bit add, with carry from LO into HI.
  - 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write vs tick in the same cycle: a write to either MTIME half suppresses the increment of the whole 64-bit value that cycle. The written half takes `wdata_i`; the other half holds.
- Compare: `irq_timer_o` ← (mtime ≥ mtimecmp), unsigned 64-bit, registered from the current register values.
- `irq_software_o` = `msip` flop, driven directly.

## Timing
- Reset, asynchronous on `rst_i` low, sets:
  - mtime = 0
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - msip = 0
  - pcnt = 0
  - irq_timer_o = 0
  - irq_software_o = 0
- `rdata_o` is 0 whenever `sel` is low. Reset mid-count discards all state immediately.
- Read latency is 0 cycles: data is valid in the same cycle as `ce_i`, matching the single-cycle MEM stage.
- Write latency: the new value is visible to reads starting in the cycle after the write edge.
- MSIP write: `irq_software_o` changes at the write edge, so it is visible the next cycle.
- Timer interrupt latency:
  - `irq_timer_o` asserts one edge after the edge at which mtime ≥ mtimecmp first holds.
  - It deasserts one edge after a write that makes mtime < mtimecmp.
  - It is level-sensitive and stays high while the condition holds.
- Software does not update MTIME/MTIMECMP atomically:
  - Writing MTIMECMP_LO before MTIMECMP_HI can raise a spurious one-cycle-delayed interrupt.
  - Software must first write 0xFFFF_FFFF to MTIMECMP_HI. No hardware guard exists.
- Reading MTIME_LO then MTIME_HI is not atomic. Software must re-read HI to detect carry.

## Test plan
- Reset/defaults: hold `rst_i`=0 for 3 cycles, then release.
  - Read 0x4000 → FFFF_FFFF; 0x4004 → FFFF_FFFF; 0xBFF8 increments from 0 by 1 per cycle.
  - Both IRQs are 0; a read outside BASE → `rdata_o`=0.
- Timer IRQ with PRESCALE=1:
  - Write MTIMECMP_HI=0, then MTIMECMP_LO=20.
  - `irq_timer_o` rises exactly one cycle after MTIME_LO reaches 20.
  - Writing MTIMECMP_LO=1000 drops it one cycle after the write.
- Carry/wrap:
  - Write MTIME_HI=0xFFFF_FFFF and MTIME_LO=0xFFFF_FFFE.
  - After 2 ticks, MTIME reads 0/0.
  - At LO=0xFFFF_FFFF→0, HI increments by exactly 1 (test with HI=5 → 6).
- Write/tick collision: a write of MTIME_LO=0x100 on a tick cycle reads back 0x100 on the next cycle (not 0x101), with HI unchanged.
- Prescaler with PRESCALE=4: mtime advances by 1 every 4 cycles; a write to MTIME does not shift the tick phase.
- MSIP:
  - Write 0x0000=0xFFFF_FFFF → `irq_software_o`=1 next cycle, and a read returns 0x1.
  - Write 0 → deasserts. A write to offset 0x0010 has no effect.
